// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared WIDTH-bit adder with a single registered result slot.
// Define ADDER_ARBITER_CARRY_EN to add the registered resp_carry output.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*WIDTH-1:0]   req_y,
    input  logic [NUM_REQ-1:0]         req_mode,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           resp_result,
    output logic [$clog2(NUM_REQ)-1:0] resp_id
`ifdef ADDER_ARBITER_CARRY_EN
    ,
    output logic                       resp_carry
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // ready never depends on the payload, and valid may rise without waiting for ready.
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic            can_accept;
    logic            transfer;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic            sel_mode;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH-1:0] add_sum;
`ifdef ADDER_ARBITER_CARRY_EN
    logic            add_carry;
`endif

    // Walk downwards so the nearest requester after last_grant wins the final assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = IW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    assign can_accept = rst_n && ((state == IDLE) || resp_ready);
    assign transfer   = can_accept && grant_found;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_x    = req_x[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_y    = req_y[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_mode = req_mode[grant_idx];

    assign op_x = sel_mode ? {sel_x[WIDTH-2:0], 1'b0} : sel_x;
    assign op_y = sel_mode ? {1'b0, sel_y[WIDTH-1:1]} : sel_y;

`ifdef ADDER_ARBITER_CARRY_EN
    assign {add_carry, add_sum} = {1'b0, op_x} + {1'b0, op_y};
`else
    assign add_sum = op_x + op_y;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_id     <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
`ifdef ADDER_ARBITER_CARRY_EN
            resp_carry  <= 1'b0;
`endif
        end else if (transfer) begin
            state       <= HOLD;
            resp_valid  <= 1'b1;
            resp_result <= add_sum;
            resp_id     <= grant_idx;
            last_grant  <= grant_idx;
`ifdef ADDER_ARBITER_CARRY_EN
            resp_carry  <= add_carry;
`endif
        end else if ((state == HOLD) && resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end
    end

endmodule
